alu_op_sequencer: RTL and testbench

Registered issue/capture stage placed directly upstream of the 32-bit combinational ALU (controlUnit). It accepts one operation (opcode, A, B) per valid/ready handshake and holds the operands stable on the ALU inputs. After a fixed settle interval it captures the ALU result and flags into an output register, then presents them downstream under a second valid/ready handshake. Invalid opcodes are caught locally and never reach the ALU.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_settle_timer.sv | 35 +++
 rtl/alu_op_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode codes, captured-flag bit positions and the
// issue/capture sequencer state type.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_LAST = OP_MUL;

  // Parked control code on the ALU while no legal op has been launched yet
  localparam logic [3:0] OP_PARK = 4'b1111;

  localparam int FLG_EQ = 4;
  localparam int FLG_LT = 3;
  localparam int FLG_C  = 2;
  localparam int FLG_OV = 1;
  localparam int FLG_Z  = 0;
  localparam int FLG_W  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } alu_seq_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_settle_timer.sv
// Loadable down-counter; done_o pulses in the cycle whose closing edge takes
// the count from 1 to 0, i.e. SETTLE_CYCLES edges after the load edge.
module alu_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = 4'(SETTLE_CYCLES);
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i && !load_i && (cnt_q == 4'd1);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage in front of the combinational ALU: registers one op onto
// the ALU, waits SETTLE_CYCLES, captures result/flags and hands them downstream.
// Optional feature macro: ALU_STICKY_FLAGS_EN (sticky carry/overflow/err bits).
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_S,
  input  logic             alu_equal,
  input  logic             alu_lessthan,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic [FLG_W-1:0] out_flags,
  output logic             out_err
`ifdef ALU_STICKY_FLAGS_EN
  ,
  input  logic             sticky_clr,
  output logic [2:0]       sticky
`endif
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
  end

  alu_seq_state_t   state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] out_s_q, out_s_d;
  logic [FLG_W-1:0] out_flags_q, out_flags_d;
  logic             out_err_q, out_err_d;
  logic [FLG_W-1:0] flags_cap;
  logic             accept;
  logic             res_hs;
  logic             timer_load;
  logic             timer_en;
  logic             timer_done;

  alu_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (timer_load),
    .en_i   (timer_en),
    .done_o (timer_done)
  );

  // in_ready_q is only ever high in IDLE, so it alone qualifies an accept
  assign accept = in_valid && in_ready_q;
  assign res_hs = out_valid_q && out_ready;

  always_comb begin
    flags_cap         = '0;
    flags_cap[FLG_EQ] = alu_equal;
    flags_cap[FLG_LT] = alu_lessthan;
    flags_cap[FLG_C]  = alu_carry;
    flags_cap[FLG_OV] = alu_overflow;
    flags_cap[FLG_Z]  = alu_zero;
  end

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    out_s_d     = out_s_q;
    out_flags_d = out_flags_q;
    out_err_d   = out_err_q;
    timer_load  = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_is_legal(in_op)) begin
            alu_a_d    = in_a;
            alu_b_d    = in_b;
            alu_ctrl_d = in_op;
            timer_load = 1'b1;
            state_d    = SETTLE;
          end else begin
            // Illegal ops never disturb the ALU; report them straight away
            out_s_d     = '0;
            out_flags_d = '0;
            out_err_d   = 1'b1;
            state_d     = RESULT;
          end
        end
      end
      SETTLE: begin
        timer_en = 1'b1;
        if (timer_done) begin
          out_s_d     = alu_S;
          out_flags_d = flags_cap;
          out_err_d   = 1'b0;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_hs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == RESULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= OP_PARK;
      out_s_q     <= '0;
      out_flags_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      out_s_q     <= out_s_d;
      out_flags_q <= out_flags_d;
      out_err_q   <= out_err_d;
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic [2:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) begin
      sticky_d = 3'b000;
    end else if (res_hs) begin
      sticky_d = sticky_q | {out_flags_q[FLG_C], out_flags_q[FLG_OV], out_err_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 3'b000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`endif

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign alu_A       = alu_a_q;
  assign alu_B       = alu_b_q;
  assign alu_control = alu_ctrl_q;
  assign out_s       = out_s_q;
  assign out_flags   = out_flags_q;
  assign out_err     = out_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU whose output
// is only meaningful once its inputs have been stable for the settle interval.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int WIDTH  = 32;
  localparam int SETTLE = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = 4'b0000;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic [WIDTH-1:0]  alu_A;
  logic [WIDTH-1:0]  alu_B;
  logic [3:0]        alu_control;
  logic [WIDTH-1:0]  alu_S;
  logic [4:0]        alu_flags;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_s;
  logic [4:0]        out_flags;
  logic              out_err;
`ifdef ALU_STICKY_FLAGS_EN
  logic              sticky_clr = 1'b0;
  logic [2:0]        sticky;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic [4:0]       f;
    logic             e;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .WIDTH(WIDTH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_control  (alu_control),
    .alu_S        (alu_S),
    .alu_equal    (alu_flags[4]),
    .alu_lessthan (alu_flags[3]),
    .alu_carry    (alu_flags[2]),
    .alu_overflow (alu_flags[1]),
    .alu_zero     (alu_flags[0]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_s        (out_s),
    .out_flags    (out_flags),
    .out_err      (out_err)
`ifdef ALU_STICKY_FLAGS_EN
    ,
    .sticky_clr   (sticky_clr),
    .sticky       (sticky)
`endif
  );

  // Reference ALU: returns {equal, lessthan, carry, overflow, zero, S}
  function automatic logic [36:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] s;
    logic        c;
    logic        ov;
    w = '0; s = '0; c = 1'b0; ov = 1'b0;
    case (op)
      OP_AND: s = a & b;
      OP_OR:  s = a | b;
      OP_XOR: s = a ^ b;
      OP_NOR: s = ~(a | b);
      OP_SLT: s = {31'd0, ($signed(a) < $signed(b))};
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        s = w[31:0]; c = w[32];
        ov = (a[31] == b[31]) && (s[31] != a[31]);
      end
      OP_SUB: begin
        w = {1'b0, a} + {1'b0, ~b} + 33'd1;
        s = w[31:0]; c = w[32];
        ov = (a[31] != b[31]) && (s[31] != a[31]);
      end
      OP_SLL: s = a << b[4:0];
      OP_SRL: s = a >> b[4:0];
      OP_SRA: s = $unsigned($signed(a) >>> b[4:0]);
      OP_MUL: s = a * b;
      default: s = '0;
    endcase
    return {(a == b), ($signed(a) < $signed(b)), c, ov, (s == 32'd0), s};
  endfunction

  // ALU output is garbage until its inputs have been stable for SETTLE-1 falling edges
  logic [67:0] snap = '0;
  int          age = 0;
  logic        settled;
  always @(negedge clk) begin
    if ({alu_A, alu_B, alu_control} !== snap) begin
      snap <= {alu_A, alu_B, alu_control};
      age  <= 0;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end
  assign settled = ({alu_A, alu_B, alu_control} === snap) && (age >= SETTLE - 1);
  assign {alu_flags, alu_S} = settled ? ref_alu(alu_control, alu_A, alu_B)
                                      : {5'b01010, 32'hDEADBEEF};

  task automatic do_accept(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'($urandom); in_a = $urandom; in_b = $urandom;
  endtask

  task automatic wait_valid(input int max_edges, output int edges);
    edges = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_err} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got %b want 000", {in_ready, out_valid, out_err});
    end
    checks++;
    if ({out_s, out_flags} !== 37'd0) begin
      errors++; $display("FAIL reset_out got %h/%b want 0/0", out_s, out_flags);
    end
    checks++;
    if ({alu_A, alu_B, alu_control} !== {64'd0, 4'b1111}) begin
      errors++; $display("FAIL reset_alu got %h %h %b want 0 0 1111", alu_A, alu_B, alu_control);
    end
`ifdef ALU_STICKY_FLAGS_EN
    checks++;
    if (sticky !== 3'b000) begin
      errors++; $display("FAIL reset_sticky got %b want 000", sticky);
    end
`endif
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge got %b want 1", in_ready);
    end
  endtask

  // Pushes a result expectation, runs one op and checks latency and captured values
  task automatic test_single(input string name, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] es, input logic [4:0] ef,
                             input logic ee, input int elat);
    int   lat;
    exp_t ex;
    sb_q.push_back('{es, ef, ee});
    do_accept(op, a, b);
    wait_valid(20, lat);
    checks++;
    if (lat !== elat) begin
      errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL %s_scoreboard got empty want entry", name);
    end else begin
      ex = sb_q.pop_front();
      if ({out_s, out_flags, out_err} !== {ex.s, ex.f, ex.e}) begin
        errors++;
        $display("FAIL %s_result got s=%h f=%b e=%b want s=%h f=%b e=%b",
                 name, out_s, out_flags, out_err, ex.s, ex.f, ex.e);
      end
    end
    handshake();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL %s_after_hs got %b want 10", name, {in_ready, out_valid});
    end
  endtask

  task automatic test_illegal();
    int   lat;
    exp_t ex;
    sb_q.push_back('{32'd0, 5'b00000, 1'b1});
    do_accept(4'b1100, 32'hAAAA5555, 32'h1);
    wait_valid(20, lat);
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL illegal_latency got %0d want 1", lat);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL illegal_scoreboard got empty want entry");
    end else begin
      ex = sb_q.pop_front();
      if ({out_s, out_flags, out_err} !== {ex.s, ex.f, ex.e}) begin
        errors++; $display("FAIL illegal_result got s=%h f=%b e=%b want s=%h f=%b e=%b",
                           out_s, out_flags, out_err, ex.s, ex.f, ex.e);
      end
    end
    checks++;
    if ({alu_control, alu_A} !== {OP_SUB, 32'h1234}) begin
      errors++; $display("FAIL illegal_alu_hold got %b %h want 0110 00001234", alu_control, alu_A);
    end
    handshake();
  endtask

  task automatic test_stall();
    int   lat;
    int   bad;
    exp_t ex;
    sb_q.push_back('{32'h0000FF00, 5'b00000, 1'b0});
    do_accept(OP_XOR, 32'h0000F0F0, 32'h00000FF0);
    wait_valid(20, lat);
    checks++;
    if (lat !== SETTLE) begin
      errors++; $display("FAIL stall_latency got %0d want %0d", lat, SETTLE);
    end
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'h11; in_b = 32'h22;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_s === 32'h0000FF00 &&
            out_err === 1'b0 && alu_A === 32'h0000F0F0 && alu_control === OP_XOR)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad);
    end
    in_valid = 1'b0;
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL stall_scoreboard got empty want entry");
    end else begin
      ex = sb_q.pop_front();
      if ({out_s, out_flags, out_err} !== {ex.s, ex.f, ex.e}) begin
        errors++; $display("FAIL stall_result got s=%h f=%b e=%b want s=%h f=%b e=%b",
                           out_s, out_flags, out_err, ex.s, ex.f, ex.e);
      end
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [36:0] r;
    int          lat;
    exp_t        ex;
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      op = 4'($urandom_range(0, 10));
      a  = $urandom;
      b  = (n % 3 == 0) ? a : $urandom;
      r  = ref_alu(op, a, b);
      sb_q.push_back('{r[31:0], r[36:32], 1'b0});
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d] got %b want 1", n, in_ready);
      end
      do_accept(op, a, b);
      wait_valid(20, lat);
      checks++;
      if (sb_q.size() == 0 || lat !== SETTLE) begin
        errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", n, lat, SETTLE);
      end else begin
        ex = sb_q.pop_front();
        if ({out_s, out_flags, out_err} !== {ex.s, ex.f, ex.e}) begin
          errors++; $display("FAIL b2b_result[%0d] op=%b got s=%h f=%b e=%b want s=%h f=%b e=%b",
                             n, op, out_s, out_flags, out_err, ex.s, ex.f, ex.e);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_settle();
    int seen;
    do_accept(OP_ADD, 32'd5, 32'd3);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_err, out_s, out_flags} !== 40'd0) begin
      errors++; $display("FAIL midrst_out got r=%b v=%b e=%b s=%h f=%b want all 0",
                         in_ready, out_valid, out_err, out_s, out_flags);
    end
    checks++;
    if ({alu_A, alu_B, alu_control} !== {64'd0, 4'b1111}) begin
      errors++; $display("FAIL midrst_alu got %h %h %b want 0 0 1111", alu_A, alu_B, alu_control);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_after got valid_cycles=%0d ready=%b want 0 1", seen, in_ready);
    end
  endtask

`ifdef ALU_STICKY_FLAGS_EN
  task automatic test_sticky();
    for (int n = 0; n < 2; n++) begin
      test_single("sticky_add", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'b00010, 1'b0, SETTLE);
      checks++;
      if (sticky !== 3'b010) begin
        errors++; $display("FAIL sticky_set[%0d] got %b want 010", n, sticky);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sticky !== 3'b010) begin
      errors++; $display("FAIL sticky_hold got %b want 010", sticky);
    end
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    checks++;
    if (sticky !== 3'b000) begin
      errors++; $display("FAIL sticky_clr got %b want 000", sticky);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single("add", OP_ADD, 32'd5, 32'd3, 32'd8, 5'b00000, 1'b0, SETTLE);
    test_single("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'b00010, 1'b0, SETTLE);
    test_single("sub_eq", OP_SUB, 32'h1234, 32'h1234, 32'h0, 5'b10101, 1'b0, SETTLE);
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_mid_settle();
`ifdef ALU_STICKY_FLAGS_EN
    test_sticky();
`endif
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
